// File: rtl/uart_avalon_bridge.sv
// Avalon-MM serial console: DATA (addr 0) pushes TX / pops RX, CONTROL (addr 1) reports status and clears OVF.
// TX and RX byte FIFOs feed an 8N1 serializer and deserializer.
module uart_avalon_bridge #(
   parameter int CLKS_PER_BIT = 434,
   parameter int TX_DEPTH     = 16,
   parameter int RX_DEPTH     = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        av_chipselect,
   input  logic        av_address,
   input  logic        av_read_n,
   output logic [31:0] av_readdata,
   input  logic        av_write_n,
   input  logic [31:0] av_writedata,
   output logic        av_waitrequest,
   input  logic        uart_rxd,
   output logic        uart_txd
);

   localparam int TAW = (TX_DEPTH > 1) ? $clog2(TX_DEPTH) : 1;
   localparam int TCW = $clog2(TX_DEPTH) + 1;
   localparam int RAW = (RX_DEPTH > 1) ? $clog2(RX_DEPTH) : 1;
   localparam int RCW = $clog2(RX_DEPTH) + 1;
   localparam int BW  = $clog2(CLKS_PER_BIT);

   localparam logic [BW-1:0]  BAUD_LAST   = BW'(CLKS_PER_BIT - 1);
   localparam logic [BW-1:0]  BAUD_HALF   = BW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [BW-1:0]  BAUD_ONE    = BW'(1);
   localparam logic [TAW-1:0] TX_PTR_LAST = TAW'(TX_DEPTH - 1);
   localparam logic [TAW-1:0] TX_PTR_ONE  = TAW'(1);
   localparam logic [TCW-1:0] TX_FULL_CNT = TCW'(TX_DEPTH);
   localparam logic [TCW-1:0] TX_CNT_ONE  = TCW'(1);
   localparam logic [RAW-1:0] RX_PTR_LAST = RAW'(RX_DEPTH - 1);
   localparam logic [RAW-1:0] RX_PTR_ONE  = RAW'(1);
   localparam logic [RCW-1:0] RX_FULL_CNT = RCW'(RX_DEPTH);
   localparam logic [RCW-1:0] RX_CNT_ONE  = RCW'(1);

   typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;
   typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_PUSH, RX_WAIT} rx_state_e;

   logic            rd_s, wr_s, rd_first_s, unused_s;
   logic            tx_push_s, tx_pop_s, tx_full_s, tx_nempty_s, tx_busy_s;
   logic            rx_push_s, rx_wr_s, rx_pop_s, rx_full_s, rx_nempty_s;
   logic            ovf_set_s, ovf_clr_s;

   logic            rd_ack_q, rd_ack_d;
   logic            ovf_q, ovf_d;
   logic [31:0]     rdata_q, rdata_d;

   logic [7:0]      tx_mem_q [TX_DEPTH];
   logic [TAW-1:0]  tx_wptr_q, tx_wptr_d, tx_rptr_q, tx_rptr_d;
   logic [TCW-1:0]  tx_count_q, tx_count_d;
   tx_state_e       tx_state_q, tx_state_d;
   logic [BW-1:0]   tx_baud_q, tx_baud_d;
   logic [2:0]      tx_bit_q, tx_bit_d;
   logic [7:0]      tx_shift_q, tx_shift_d;
   logic            txd_q, txd_d;

   logic [7:0]      rx_mem_q [RX_DEPTH];
   logic [RAW-1:0]  rx_wptr_q, rx_wptr_d, rx_rptr_q, rx_rptr_d;
   logic [RCW-1:0]  rx_count_q, rx_count_d;
   rx_state_e       rx_state_q, rx_state_d;
   logic [BW-1:0]   rx_baud_q, rx_baud_d;
   logic [2:0]      rx_bit_q, rx_bit_d;
   logic [7:0]      rx_shift_q, rx_shift_d;
   logic            rxd_meta_q, rxd_meta_d, rxd_sync_q, rxd_sync_d;

   // A simultaneous read and write is illegal; the write loses.
   assign rd_s        = av_chipselect & ~av_read_n;
   assign wr_s        = av_chipselect & ~av_write_n & ~rd_s;
   assign rd_first_s  = rd_s & ~rd_ack_q;
   assign tx_full_s   = (tx_count_q == TX_FULL_CNT);
   assign tx_nempty_s = (tx_count_q != {TCW{1'b0}});
   assign tx_busy_s   = (tx_state_q != TX_IDLE) | tx_nempty_s;
   assign rx_full_s   = (rx_count_q == RX_FULL_CNT);
   assign rx_nempty_s = (rx_count_q != {RCW{1'b0}});
   assign tx_push_s   = wr_s & ~av_address & ~tx_full_s;
   assign rx_pop_s    = rd_first_s & ~av_address & rx_nempty_s;
   assign rx_wr_s     = rx_push_s & (~rx_full_s | rx_pop_s);
   assign ovf_set_s   = rx_push_s & rx_full_s & ~rx_pop_s;
   assign ovf_clr_s   = wr_s & av_address & av_writedata[2];
   assign unused_s    = ^av_writedata[31:8];

   assign av_waitrequest = rst_n & (rd_first_s | (wr_s & ~av_address & tx_full_s));
   assign av_readdata    = rdata_q;
   assign uart_txd       = txd_q;

   always_comb begin
      rd_ack_d = rd_first_s;
      ovf_d    = ovf_set_s | (ovf_q & ~ovf_clr_s);
      rdata_d  = rdata_q;
      if (rd_first_s) begin
         if (!av_address) begin
            if (rx_nempty_s) begin
               rdata_d = {16'(rx_count_q - RX_CNT_ONE), 1'b1, 7'b0000000, rx_mem_q[rx_rptr_q]};
            end else begin
               rdata_d = 32'h0000_0000;
            end
         end else begin
            rdata_d = {16'(TX_FULL_CNT - tx_count_q), 13'h0000, ovf_q, tx_busy_s, rx_nempty_s};
         end
      end else begin
         rdata_d = rdata_q;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rd_ack_q <= 1'b0;
         ovf_q    <= 1'b0;
         rdata_q  <= 32'h0000_0000;
      end else begin
         rd_ack_q <= rd_ack_d;
         ovf_q    <= ovf_d;
         rdata_q  <= rdata_d;
      end
   end

   // Pointer/occupancy bookkeeping; a push and a pop together leave the count unchanged, even when full.
   always_comb begin
      tx_wptr_d  = tx_wptr_q;
      tx_rptr_d  = tx_rptr_q;
      rx_wptr_d  = rx_wptr_q;
      rx_rptr_d  = rx_rptr_q;
      if (tx_push_s) begin
         tx_wptr_d = (tx_wptr_q == TX_PTR_LAST) ? {TAW{1'b0}} : tx_wptr_q + TX_PTR_ONE;
      end else begin
         tx_wptr_d = tx_wptr_q;
      end
      if (tx_pop_s) begin
         tx_rptr_d = (tx_rptr_q == TX_PTR_LAST) ? {TAW{1'b0}} : tx_rptr_q + TX_PTR_ONE;
      end else begin
         tx_rptr_d = tx_rptr_q;
      end
      if (rx_wr_s) begin
         rx_wptr_d = (rx_wptr_q == RX_PTR_LAST) ? {RAW{1'b0}} : rx_wptr_q + RX_PTR_ONE;
      end else begin
         rx_wptr_d = rx_wptr_q;
      end
      if (rx_pop_s) begin
         rx_rptr_d = (rx_rptr_q == RX_PTR_LAST) ? {RAW{1'b0}} : rx_rptr_q + RX_PTR_ONE;
      end else begin
         rx_rptr_d = rx_rptr_q;
      end
      case ({tx_push_s, tx_pop_s})
         2'b10:   tx_count_d = tx_count_q + TX_CNT_ONE;
         2'b01:   tx_count_d = tx_count_q - TX_CNT_ONE;
         default: tx_count_d = tx_count_q;
      endcase
      case ({rx_wr_s, rx_pop_s})
         2'b10:   rx_count_d = rx_count_q + RX_CNT_ONE;
         2'b01:   rx_count_d = rx_count_q - RX_CNT_ONE;
         default: rx_count_d = rx_count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         tx_wptr_q  <= {TAW{1'b0}};
         tx_rptr_q  <= {TAW{1'b0}};
         tx_count_q <= {TCW{1'b0}};
         rx_wptr_q  <= {RAW{1'b0}};
         rx_rptr_q  <= {RAW{1'b0}};
         rx_count_q <= {RCW{1'b0}};
      end else begin
         tx_wptr_q  <= tx_wptr_d;
         tx_rptr_q  <= tx_rptr_d;
         tx_count_q <= tx_count_d;
         rx_wptr_q  <= rx_wptr_d;
         rx_rptr_q  <= rx_rptr_d;
         rx_count_q <= rx_count_d;
      end
   end

   // Storage carries no reset; occupancy alone decides what is valid.
   always_ff @(posedge clk) begin
      if (tx_push_s) begin
         tx_mem_q[tx_wptr_q] <= av_writedata[7:0];
      end
      if (rx_wr_s) begin
         rx_mem_q[rx_wptr_q] <= rx_shift_q;
      end
   end

   always_comb begin
      tx_state_d = tx_state_q;
      tx_baud_d  = tx_baud_q;
      tx_bit_d   = tx_bit_q;
      tx_shift_d = tx_shift_q;
      txd_d      = txd_q;
      tx_pop_s   = 1'b0;
      case (tx_state_q)
         TX_IDLE: begin
            txd_d = 1'b1;
            if (tx_nempty_s) begin
               tx_pop_s   = 1'b1;
               tx_shift_d = tx_mem_q[tx_rptr_q];
               tx_baud_d  = {BW{1'b0}};
               txd_d      = 1'b0;
               tx_state_d = TX_START;
            end else begin
               tx_state_d = TX_IDLE;
            end
         end
         TX_START: begin
            if (tx_baud_q == BAUD_LAST) begin
               tx_baud_d  = {BW{1'b0}};
               tx_bit_d   = 3'd0;
               txd_d      = tx_shift_q[0];
               tx_state_d = TX_DATA;
            end else begin
               tx_baud_d  = tx_baud_q + BAUD_ONE;
            end
         end
         TX_DATA: begin
            if (tx_baud_q == BAUD_LAST) begin
               tx_baud_d = {BW{1'b0}};
               if (tx_bit_q == 3'd7) begin
                  txd_d      = 1'b1;
                  tx_state_d = TX_STOP;
               end else begin
                  tx_bit_d   = tx_bit_q + 3'd1;
                  tx_shift_d = {1'b0, tx_shift_q[7:1]};
                  txd_d      = tx_shift_q[1];
               end
            end else begin
               tx_baud_d = tx_baud_q + BAUD_ONE;
            end
         end
         TX_STOP: begin
            // Chain straight into the next start bit so queued bytes leave without an idle gap.
            if (tx_baud_q == BAUD_LAST) begin
               tx_baud_d = {BW{1'b0}};
               if (tx_nempty_s) begin
                  tx_pop_s   = 1'b1;
                  tx_shift_d = tx_mem_q[tx_rptr_q];
                  txd_d      = 1'b0;
                  tx_state_d = TX_START;
               end else begin
                  txd_d      = 1'b1;
                  tx_state_d = TX_IDLE;
               end
            end else begin
               tx_baud_d = tx_baud_q + BAUD_ONE;
            end
         end
         default: begin
            txd_d      = 1'b1;
            tx_state_d = TX_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         tx_state_q <= TX_IDLE;
         tx_baud_q  <= {BW{1'b0}};
         tx_bit_q   <= 3'd0;
         tx_shift_q <= 8'h00;
         txd_q      <= 1'b1;
      end else begin
         tx_state_q <= tx_state_d;
         tx_baud_q  <= tx_baud_d;
         tx_bit_q   <= tx_bit_d;
         tx_shift_q <= tx_shift_d;
         txd_q      <= txd_d;
      end
   end

   always_comb begin
      rxd_meta_d = uart_rxd;
      rxd_sync_d = rxd_meta_q;
      rx_state_d = rx_state_q;
      rx_baud_d  = rx_baud_q;
      rx_bit_d   = rx_bit_q;
      rx_shift_d = rx_shift_q;
      rx_push_s  = 1'b0;
      case (rx_state_q)
         RX_IDLE: begin
            if (!rxd_sync_q) begin
               rx_baud_d  = {BW{1'b0}};
               rx_state_d = RX_START;
            end else begin
               rx_state_d = RX_IDLE;
            end
         end
         RX_START: begin
            // Mid-bit check rejects glitches shorter than half a bit.
            if (rx_baud_q == BAUD_HALF) begin
               rx_baud_d = {BW{1'b0}};
               rx_bit_d  = 3'd0;
               if (rxd_sync_q) begin
                  rx_state_d = RX_IDLE;
               end else begin
                  rx_state_d = RX_DATA;
               end
            end else begin
               rx_baud_d = rx_baud_q + BAUD_ONE;
            end
         end
         RX_DATA: begin
            if (rx_baud_q == BAUD_LAST) begin
               rx_baud_d  = {BW{1'b0}};
               rx_shift_d = {rxd_sync_q, rx_shift_q[7:1]};
               if (rx_bit_q == 3'd7) begin
                  rx_state_d = RX_STOP;
               end else begin
                  rx_bit_d   = rx_bit_q + 3'd1;
               end
            end else begin
               rx_baud_d = rx_baud_q + BAUD_ONE;
            end
         end
         RX_STOP: begin
            if (rx_baud_q == BAUD_LAST) begin
               rx_baud_d  = {BW{1'b0}};
               rx_state_d = rxd_sync_q ? RX_PUSH : RX_WAIT;
            end else begin
               rx_baud_d = rx_baud_q + BAUD_ONE;
            end
         end
         RX_PUSH: begin
            rx_push_s  = 1'b1;
            rx_state_d = RX_IDLE;
         end
         RX_WAIT: begin
            if (rxd_sync_q) begin
               rx_state_d = RX_IDLE;
            end else begin
               rx_state_d = RX_WAIT;
            end
         end
         default: begin
            rx_state_d = RX_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rxd_meta_q <= 1'b1;
         rxd_sync_q <= 1'b1;
         rx_state_q <= RX_IDLE;
         rx_baud_q  <= {BW{1'b0}};
         rx_bit_q   <= 3'd0;
         rx_shift_q <= 8'h00;
      end else begin
         rxd_meta_q <= rxd_meta_d;
         rxd_sync_q <= rxd_sync_d;
         rx_state_q <= rx_state_d;
         rx_baud_q  <= rx_baud_d;
         rx_bit_q   <= rx_bit_d;
         rx_shift_q <= rx_shift_d;
      end
   end

endmodule

// File: tb/tb_uart_avalon_bridge.sv
// Scoreboard bench for uart_avalon_bridge: expected read data and TX bytes are queued at issue time
// and consumed by independent monitors on the Avalon read port and on uart_txd.
module tb_uart_avalon_bridge;
   localparam int CPB = 8;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        av_chipselect = 1'b0;
   logic        av_address = 1'b0;
   logic        av_read_n = 1'b1;
   logic        av_write_n = 1'b1;
   logic [31:0] av_writedata = 32'h0000_0000;
   logic        uart_rxd = 1'b1;
   logic [31:0] av_readdata;
   logic        av_waitrequest;
   logic        uart_txd;

   int          cyc = 0;
   int          n_pass = 0;
   int          n_total = 0;
   logic [31:0] rd_q [$];
   logic [7:0]  tx_q [$];
   int          tx_prev = -1;
   int          tx_last_start = -1000;
   bit          tx_contig = 1'b0;

   uart_avalon_bridge #(.CLKS_PER_BIT(CPB), .TX_DEPTH(16), .RX_DEPTH(16)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .av_chipselect  (av_chipselect),
      .av_address     (av_address),
      .av_read_n      (av_read_n),
      .av_readdata    (av_readdata),
      .av_write_n     (av_write_n),
      .av_writedata   (av_writedata),
      .av_waitrequest (av_waitrequest),
      .uart_rxd       (uart_rxd),
      .uart_txd       (uart_txd)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
   endtask

   task automatic fail_now(input string nm, input string why);
      n_total++;
      $display("FAIL %s: %s", nm, why);
   endtask

   // All stimulus tasks start and end at posedge+2.
   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic bus_read(input logic a, input logic [31:0] exp, output int waits);
      rd_q.push_back(exp);
      av_chipselect = 1'b1; av_read_n = 1'b0; av_address = a;
      waits = 0;
      @(negedge clk);
      while (av_waitrequest === 1'b1 && waits < 200) begin
         waits++;
         @(negedge clk);
      end
      if (waits >= 200) fail_now("rd_wait", "waitrequest never dropped");
      @(posedge clk); #2;
      av_chipselect = 1'b0; av_read_n = 1'b1;
   endtask

   task automatic bus_write(input logic a, input logic [31:0] d, output int waits, output int acc);
      if (!a) tx_q.push_back(d[7:0]);
      av_chipselect = 1'b1; av_write_n = 1'b0; av_address = a; av_writedata = d;
      waits = 0;
      @(negedge clk);
      while (av_waitrequest === 1'b1 && waits < 200) begin
         waits++;
         @(negedge clk);
      end
      if (waits >= 200) fail_now("wr_wait", "waitrequest never dropped");
      acc = cyc;
      @(posedge clk); #2;
      av_chipselect = 1'b0; av_write_n = 1'b1;
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop_bit);
      logic [9:0] frame;
      frame = {stop_bit, b, 1'b0};
      for (int i = 0; i < 10; i++) begin
         uart_rxd = frame[i];
         repeat (CPB) @(posedge clk);
         #2;
      end
      uart_rxd = 1'b1;
   endtask

   task automatic wait_tx_drain();
      int n;
      n = 0;
      while (tx_q.size() != 0 && n < 4000) begin
         idle(1);
         n++;
      end
      if (tx_q.size() != 0) fail_now("tx_drain", "expected TX bytes never appeared");
   endtask

   // Read-port monitor: every completed read consumes one expectation.
   always @(negedge clk) begin
      if (rst_n && av_chipselect && !av_read_n && av_waitrequest === 1'b0) begin
         if (rd_q.size() == 0) fail_now("rd_unexpected", "read completed with no expectation queued");
         else chk("readdata", av_readdata, rd_q.pop_front());
      end
   end

   // Serial-line monitor: decode 8N1 at mid-bit and compare against queued bytes.
   initial begin
      int st;
      logic [7:0] b;
      logic stopb;
      forever begin
         @(negedge clk);
         if (rst_n === 1'b1 && uart_txd === 1'b0) begin
            st = cyc;
            if (tx_contig && tx_prev >= 0) chk("tx_gap", st - tx_prev, 32'd80);
            tx_prev = st;
            tx_last_start = st;
            repeat (CPB / 2) @(negedge clk);
            for (int i = 0; i < 8; i++) begin
               repeat (CPB) @(negedge clk);
               b[i] = uart_txd;
            end
            repeat (CPB) @(negedge clk);
            stopb = uart_txd;
            if (tx_q.size() == 0) fail_now("tx_unexpected", "frame seen with nothing queued");
            else chk("tx_frame", {23'h0, stopb, b}, {23'h0, 1'b1, tx_q.pop_front()});
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int w, acc, wsum;
      // Reset with a read pending: waitrequest must stay low.
      av_chipselect = 1'b1; av_read_n = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      chk("rst_waitreq", {31'h0, av_waitrequest}, 32'h0);
      chk("rst_txd", {31'h0, uart_txd}, 32'h1);
      chk("rst_rdata", av_readdata, 32'h0);
      av_chipselect = 1'b0; av_read_n = 1'b1; rst_n = 1'b1;
      idle(1);
      bus_read(1'b1, 32'h0010_0000, w);
      chk("rst_ctrl_waits", w, 32'd1);

      // Single TX frame
      bus_write(1'b0, 32'hFFFF_FF41, w, acc);
      chk("tx_wr_waits", w, 32'd0);
      idle(5);
      chk("tx_start_lat", tx_last_start - acc, 32'd2);
      idle(10);
      bus_read(1'b1, 32'h0010_0002, w);
      wait_tx_drain();
      idle(10);
      bus_read(1'b1, 32'h0010_0000, w);

      // TX back-pressure: first byte leaves at once, 16 more fill the FIFO, the 18th stalls
      tx_contig = 1'b1; tx_prev = -1; wsum = 0;
      for (int i = 0; i < 17; i++) begin
         bus_write(1'b0, 32'h30 + i, w, acc);
         wsum += w;
      end
      chk("bp_no_wait", wsum, 32'd0);
      bus_write(1'b0, 32'h0000_0042, w, acc);
      chk("bp_stall_waits", w, 32'd65);
      wait_tx_drain();
      idle(10);
      tx_contig = 1'b0;
      bus_read(1'b1, 32'h0010_0000, w);

      // RX path
      send_byte(8'h5A, 1'b1);
      idle(4);
      bus_read(1'b0, 32'h0000_805A, w);
      bus_read(1'b0, 32'h0000_0000, w);

      // Framing error, then overflow
      send_byte(8'h33, 1'b0);
      idle(2 * CPB);
      bus_read(1'b1, 32'h0010_0000, w);
      for (int i = 0; i < 17; i++) send_byte(8'h10 + 8'(i), 1'b1);
      idle(4);
      bus_read(1'b1, 32'h0010_0005, w);
      bus_read(1'b0, 32'h000F_8010, w);
      bus_write(1'b1, 32'h0000_0004, w, acc);
      chk("ctrl_wr_waits", w, 32'd0);
      bus_read(1'b1, 32'h0010_0001, w);
      for (int i = 0; i < 15; i++) bus_read(1'b0, ((32'd14 - i) << 16) | 32'h8000 | (32'h11 + i), w);
      bus_read(1'b0, 32'h0000_0000, w);

      // Held read across two back-to-back accesses: one pop each
      send_byte(8'hA1, 1'b1);
      send_byte(8'hB2, 1'b1);
      idle(4);
      rd_q.push_back(32'h0001_80A1);
      rd_q.push_back(32'h0000_80B2);
      av_chipselect = 1'b1; av_read_n = 1'b0; av_address = 1'b0;
      idle(4);
      av_chipselect = 1'b0; av_read_n = 1'b1;
      chk("held_reads_done", rd_q.size(), 32'd0);
      bus_read(1'b1, 32'h0010_0000, w);

      idle(5);
      chk("rd_q_empty", rd_q.size(), 32'd0);
      chk("tx_q_empty", tx_q.size(), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
